// File: rtl/nrf_spi_txn_ctrl.sv
// ---------------------------------------------------------------------------
// nrf_spi_txn_ctrl
//
// Purpose:
//   Transaction sequencer that sits in front of a Mode 0 byte-level SPI master
//   talking to an nRF24L01 radio. One request becomes one CSN-framed SPI
//   transaction: a command byte followed by 0..MAX_LEN data bytes. CSN is
//   kept low across all bytes through spi_hold_csn. The radio STATUS byte
//   (shifted in during the command byte) is captured. Write payload is
//   pulled from a valid/ready stream. Read payload is pushed out as
//   rdata/rdata_valid pulses. After CSN is released the block enforces a
//   GAP_CYCLES quiet period before it reports done and accepts new work.
//
// Parameters:
//   MAX_LEN     maximum data bytes per transaction (len is clamped to this)
//   GAP_CYCLES  clk cycles of CSN-high quiet time after a transaction (>= 1)
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req, cmd, len, rw   request pulse and its command byte, length, direction
//   wdata, wdata_valid  write payload stream in
//   wdata_ready         one-cycle pulse: wdata was taken
//   rdata, rdata_valid  read payload byte out with one-cycle valid pulse
//   status              rx byte of the command phase (nRF STATUS)
//   busy, done          transaction in progress / end-of-gap pulse
//   spi_start           one-cycle byte-start pulse to the SPI master
//   spi_tx_byte         byte to send, stable from spi_start to spi_done
//   spi_rx_byte         byte received by the SPI master
//   spi_done, spi_busy  SPI master byte-complete pulse and busy flag
//   spi_hold_csn        keeps CSN asserted between bytes
// ---------------------------------------------------------------------------
module nrf_spi_txn_ctrl #(
    parameter int MAX_LEN    = 32,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] cmd,
    input  logic [5:0] len,
    input  logic       rw,
    input  logic [7:0] wdata,
    input  logic       wdata_valid,
    output logic       wdata_ready,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic [7:0] status,
    output logic       busy,
    output logic       done,
    output logic       spi_start,
    output logic [7:0] spi_tx_byte,
    input  logic [7:0] spi_rx_byte,
    input  logic       spi_done,
    input  logic       spi_busy,
    output logic       spi_hold_csn
);

    localparam int             GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [5:0]     MAX_LEN_L = 6'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_ISSUE,
        ST_CMD_WAIT,
        ST_DATA_FETCH,
        ST_DATA_ISSUE,
        ST_DATA_WAIT,
        ST_LAST,
        ST_GAP
    } state_t;

    state_t           state, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic             rw_q, rw_d;
    logic [5:0]       remaining, remaining_d;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_d;

    logic       wdata_ready_d;
    logic [7:0] rdata_d;
    logic       rdata_valid_d;
    logic [7:0] status_d;
    logic       busy_d;
    logic       done_d;
    logic       spi_start_d;
    logic [7:0] spi_tx_byte_d;
    logic       spi_hold_csn_d;

    // State and every output live in this one register bank, so all outputs
    // are glitch-free flops. Reset drops spi_hold_csn, which lets the SPI
    // master (reset on the same net) release CSN straight away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cmd_q        <= 8'h00;
            rw_q         <= 1'b0;
            remaining    <= 6'd0;
            gap_cnt      <= '0;
            wdata_ready  <= 1'b0;
            rdata        <= 8'h00;
            rdata_valid  <= 1'b0;
            status       <= 8'h00;
            busy         <= 1'b0;
            done         <= 1'b0;
            spi_start    <= 1'b0;
            spi_tx_byte  <= 8'h00;
            spi_hold_csn <= 1'b0;
        end else begin
            state        <= state_d;
            cmd_q        <= cmd_d;
            rw_q         <= rw_d;
            remaining    <= remaining_d;
            gap_cnt      <= gap_cnt_d;
            wdata_ready  <= wdata_ready_d;
            rdata        <= rdata_d;
            rdata_valid  <= rdata_valid_d;
            status       <= status_d;
            busy         <= busy_d;
            done         <= done_d;
            spi_start    <= spi_start_d;
            spi_tx_byte  <= spi_tx_byte_d;
            spi_hold_csn <= spi_hold_csn_d;
        end
    end

    // Next-state and next-output logic. Pulse outputs (spi_start,
    // wdata_ready, rdata_valid, done) default to 0 so they last one cycle;
    // everything else holds its value unless a state changes it. Because
    // spi_start is registered, the spi_busy check happens one cycle before the
    // pulse is seen, which is safe since this block is the only thing that
    // can make the master busy.
    always_comb begin
        state_d        = state;
        cmd_d          = cmd_q;
        rw_d           = rw_q;
        remaining_d    = remaining;
        gap_cnt_d      = gap_cnt;
        wdata_ready_d  = 1'b0;
        rdata_d        = rdata;
        rdata_valid_d  = 1'b0;
        status_d       = status;
        busy_d         = busy;
        done_d         = 1'b0;
        spi_start_d    = 1'b0;
        spi_tx_byte_d  = spi_tx_byte;
        spi_hold_csn_d = spi_hold_csn;

        case (state)
            ST_IDLE: begin
                // done is high during the first IDLE cycle; a req arriving
                // together with done is deliberately not taken.
                if (req && !done) begin
                    cmd_d       = cmd;
                    rw_d        = rw;
                    remaining_d = (len > MAX_LEN_L) ? MAX_LEN_L : len;
                    busy_d      = 1'b1;
                    state_d     = ST_CMD_ISSUE;
                end
            end

            ST_CMD_ISSUE: begin
                if (!spi_busy) begin
                    spi_start_d    = 1'b1;
                    spi_tx_byte_d  = cmd_q;
                    spi_hold_csn_d = 1'b1;
                    state_d        = ST_CMD_WAIT;
                end
            end

            ST_CMD_WAIT: begin
                if (spi_done) begin
                    status_d = spi_rx_byte;
                    if (remaining == 6'd0) begin
                        // Releasing hold on the transition makes CSN rise the
                        // cycle after the final spi_done.
                        spi_hold_csn_d = 1'b0;
                        state_d        = ST_LAST;
                    end else begin
                        state_d = ST_DATA_FETCH;
                    end
                end
            end

            ST_DATA_FETCH: begin
                if (!rw_q) begin
                    spi_tx_byte_d = 8'hFF;
                    state_d       = ST_DATA_ISSUE;
                end else if (wdata_valid) begin
                    spi_tx_byte_d = wdata;
                    wdata_ready_d = 1'b1;
                    state_d       = ST_DATA_ISSUE;
                end
            end

            ST_DATA_ISSUE: begin
                if (!spi_busy) begin
                    spi_start_d = 1'b1;
                    state_d     = ST_DATA_WAIT;
                end
            end

            ST_DATA_WAIT: begin
                if (spi_done) begin
                    if (!rw_q) begin
                        rdata_d       = spi_rx_byte;
                        rdata_valid_d = 1'b1;
                    end
                    remaining_d = remaining - 6'd1;
                    if (remaining == 6'd1) begin
                        spi_hold_csn_d = 1'b0;
                        state_d        = ST_LAST;
                    end else begin
                        state_d = ST_DATA_FETCH;
                    end
                end
            end

            ST_LAST: begin
                if (!spi_busy) begin
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nrf_spi_txn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nrf_spi_txn_ctrl
//
// Purpose:
//   Self-checking bench for nrf_spi_txn_ctrl. A small behavioural Mode 0 SPI
//   master plus nRF slave answers spi_start with a 16-half-period byte and
//   returns bytes from a MISO queue. A write-payload source feeds wdata with
//   an optional stall. Expected MOSI bytes and read bytes are queued when a
//   request is driven and compared as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_nrf_spi_txn_ctrl;

    localparam int GAP_CYCLES = 8;
    localparam int MAX_LEN    = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [7:0] cmd;
    logic [5:0] len;
    logic       rw;
    logic [7:0] wdata;
    logic       wdata_valid;
    logic       wdata_ready;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic [7:0] status;
    logic       busy;
    logic       done;
    logic       spi_start;
    logic [7:0] spi_tx_byte;
    logic [7:0] spi_rx_byte;
    logic       spi_done;
    logic       spi_busy;
    logic       spi_hold_csn;

    typedef struct {
        logic [7:0] cmd;
        logic [5:0] len;
        logic       rw;
        int         nbytes;
        logic [7:0] status;
        logic [7:0] base;
        int         stall_at;
        int         stall_len;
        int         exp_starts;
        int         exp_ready;
        int         exp_rvalid;
        int         exp_window;
    } vec_t;

    vec_t vecs[6];

    int checks;
    int failures;

    int n_start, n_ready, n_rvalid, n_done;
    int csn_falls, csn_rises, csn_rise_cyc, done_cyc;
    int start_while_busy, tx_unstable, stall_viol, stall_window;
    int extra_mosi, extra_rdata, miso_under;
    int cyc;
    int popped, stall_at, stall_len, stall_left;

    int         start_cyc_q[$];
    int         rise_cyc_q[$];
    logic [7:0] miso_q[$];
    logic [7:0] wq[$];
    logic [7:0] exp_mosi_q[$];
    logic [7:0] exp_rdata_q[$];

    logic       m_busy;
    int         m_cnt;
    logic [7:0] m_tx;
    logic       csn;
    logic       csn_next;
    logic       was_busy;

    assign spi_busy = m_busy;

    nrf_spi_txn_ctrl #(
        .MAX_LEN    (MAX_LEN),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .cmd          (cmd),
        .len          (len),
        .rw           (rw),
        .wdata        (wdata),
        .wdata_valid  (wdata_valid),
        .wdata_ready  (wdata_ready),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .status       (status),
        .busy         (busy),
        .done         (done),
        .spi_start    (spi_start),
        .spi_tx_byte  (spi_tx_byte),
        .spi_rx_byte  (spi_rx_byte),
        .spi_done     (spi_done),
        .spi_busy     (spi_busy),
        .spi_hold_csn (spi_hold_csn)
    );

    always #5 clk = ~clk;

    // Cycle counter used to timestamp CSN edges, starts and done.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // SPI master / slave model, payload source and monitors, all evaluated on
    // the falling edge so DUT outputs are stable and DUT inputs change away
    // from the active edge. A byte takes 16 SCLK half-periods; spi_done pulses
    // on the last one and busy drops one cycle later.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            m_busy      = 1'b0;
            m_cnt       = 0;
            m_tx        = 8'h00;
            spi_done    = 1'b0;
            spi_rx_byte = 8'h00;
            csn         = 1'b1;
            stall_left  = 0;
            wdata_valid = 1'b0;
            wdata       = 8'h00;
        end else begin
            was_busy = m_busy;
            spi_done = 1'b0;

            if (spi_start && was_busy) start_while_busy++;
            if (was_busy && (spi_tx_byte != m_tx)) tx_unstable++;

            if (was_busy) begin
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                end else begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        spi_done = 1'b1;
                        if (miso_q.size() > 0) spi_rx_byte = miso_q.pop_front();
                        else begin
                            miso_under++;
                            spi_rx_byte = 8'h00;
                        end
                    end
                end
            end

            if (spi_start && !was_busy) begin
                m_busy = 1'b1;
                m_cnt  = 16;
                m_tx   = spi_tx_byte;
                n_start++;
                start_cyc_q.push_back(cyc);
                if (exp_mosi_q.size() == 0) extra_mosi++;
                else checkOutput("mosi_byte", int'(spi_tx_byte), int'(exp_mosi_q.pop_front()));
            end

            csn_next = !(m_busy || spi_hold_csn);
            if (csn && !csn_next) csn_falls++;
            if (!csn && csn_next) begin
                csn_rises++;
                csn_rise_cyc = cyc;
                rise_cyc_q.push_back(cyc);
            end
            csn = csn_next;

            if (wdata_ready) n_ready++;
            if (rdata_valid) begin
                n_rvalid++;
                if (exp_rdata_q.size() == 0) extra_rdata++;
                else checkOutput("rdata", int'(rdata), int'(exp_rdata_q.pop_front()));
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end

            // Late part of the payload stall: the previous byte has finished,
            // so the bus must be idle with CSN held low.
            if (stall_left > 0 && stall_left <= 25) begin
                stall_window++;
                if (spi_start || m_busy || csn) stall_viol++;
            end

            if (wdata_ready) begin
                if (wq.size() > 0) void'(wq.pop_front());
                popped++;
                if (popped == stall_at) stall_left = stall_len;
            end else if (stall_left > 0) begin
                stall_left--;
            end
            wdata_valid = (wq.size() > 0) && (stall_left == 0);
            wdata       = (wq.size() > 0) ? wq[0] : 8'h00;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clearCounters();
        n_start = 0; n_ready = 0; n_rvalid = 0; n_done = 0;
        csn_falls = 0; csn_rises = 0; csn_rise_cyc = 0; done_cyc = 0;
        start_while_busy = 0; tx_unstable = 0; stall_viol = 0; stall_window = 0;
        extra_mosi = 0; extra_rdata = 0; miso_under = 0; popped = 0;
        start_cyc_q.delete();
        rise_cyc_q.delete();
    endtask

    // Fill slave, source and scoreboard queues for one transaction.
    task automatic loadTxn(input vec_t v);
        logic [7:0] b;
        miso_q.delete();
        wq.delete();
        exp_mosi_q.delete();
        exp_rdata_q.delete();
        miso_q.push_back(v.status);
        exp_mosi_q.push_back(v.cmd);
        for (int i = 0; i < v.nbytes; i++) begin
            b = v.base + 8'(i * 17);
            miso_q.push_back(b);
            if (v.rw) begin
                wq.push_back(b);
                exp_mosi_q.push_back(b);
            end else begin
                exp_mosi_q.push_back(8'hFF);
                exp_rdata_q.push_back(b);
            end
        end
        stall_at  = v.stall_at;
        stall_len = v.stall_len;
        clearCounters();
    endtask

    task automatic issueReq(input vec_t v);
        cmd = v.cmd;
        len = v.len;
        rw  = v.rw;
        req = 1'b1;
        tick();
        req = 1'b0;
        checkOutput("busy_after_req", int'(busy), 1);
    endtask

    task automatic applyStimulus(input vec_t v);
        loadTxn(v);
        issueReq(v);
        for (int i = 0; i < 5000 && n_done == 0; i++) tick();
        repeat (3) tick();
    endtask

    task automatic checkTxn(input vec_t v, input string tag);
        checkOutput({tag, "_done_count"}, n_done, 1);
        checkOutput({tag, "_starts"}, n_start, v.exp_starts);
        checkOutput({tag, "_wdata_ready"}, n_ready, v.exp_ready);
        checkOutput({tag, "_rdata_valid"}, n_rvalid, v.exp_rvalid);
        checkOutput({tag, "_status"}, int'(status), int'(v.status));
        checkOutput({tag, "_csn_falls"}, csn_falls, 1);
        checkOutput({tag, "_csn_rises"}, csn_rises, 1);
        checkOutput({tag, "_gap_ok"}, int'((done_cyc - csn_rise_cyc) >= GAP_CYCLES), 1);
        checkOutput({tag, "_mosi_left"}, exp_mosi_q.size(), 0);
        checkOutput({tag, "_rdata_left"}, exp_rdata_q.size(), 0);
        checkOutput({tag, "_extra_mosi"}, extra_mosi, 0);
        checkOutput({tag, "_extra_rdata"}, extra_rdata, 0);
        checkOutput({tag, "_start_while_busy"}, start_while_busy, 0);
        checkOutput({tag, "_tx_unstable"}, tx_unstable, 0);
        checkOutput({tag, "_stall_viol"}, stall_viol, 0);
        checkOutput({tag, "_stall_window"}, stall_window, v.exp_window);
        checkOutput({tag, "_miso_under"}, miso_under, 0);
        checkOutput({tag, "_busy_end"}, int'(busy), 0);
        checkOutput({tag, "_hold_end"}, int'(spi_hold_csn), 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        stall_at = -1;
        stall_len = 0;
        clearCounters();
        req = 1'b0;
        cmd = 8'h00;
        len = 6'd0;
        rw  = 1'b0;
        rst = 1'b0;

        //            cmd    len     rw    n   status base   stAt stLen st  rdy rv  win
        vecs[0] = '{8'h20, 6'd1,  1'b1, 1,  8'h0E, 8'h0E, -1, 0,  2,  1,  0,  0};
        vecs[1] = '{8'h61, 6'd3,  1'b0, 3,  8'h0E, 8'hA1, -1, 0,  4,  0,  3,  0};
        vecs[2] = '{8'hE1, 6'd0,  1'b0, 0,  8'h0E, 8'h00, -1, 0,  1,  0,  0,  0};
        vecs[3] = '{8'hA0, 6'd40, 1'b1, 32, 8'h0E, 8'h40, 2,  50, 33, 32, 0,  25};
        vecs[4] = '{8'h61, 6'd63, 1'b0, 32, 8'h2E, 8'h05, -1, 0,  33, 0,  32, 0};
        vecs[5] = '{8'hA0, 6'd32, 1'b1, 32, 8'h4E, 8'h07, -1, 0,  33, 32, 0,  0};

        repeat (3) tick();
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_spi_start", int'(spi_start), 0);
        checkOutput("rst_hold_csn", int'(spi_hold_csn), 0);
        checkOutput("rst_wdata_ready", int'(wdata_ready), 0);
        checkOutput("rst_rdata_valid", int'(rdata_valid), 0);
        checkOutput("rst_rdata", int'(rdata), 0);
        checkOutput("rst_status", int'(status), 0);
        checkOutput("rst_tx_byte", int'(spi_tx_byte), 0);
        rst = 1'b1;
        repeat (3) tick();

        for (int k = 0; k < 6; k++) begin
            applyStimulus(vecs[k]);
            checkTxn(vecs[k], $sformatf("v%0d", k));
        end

        // Back-to-back: req held high through two transactions.
        loadTxn(vecs[2]);
        miso_q.delete();
        exp_mosi_q.delete();
        exp_rdata_q.delete();
        miso_q = '{8'h0E, 8'h11, 8'h0E, 8'h22};
        exp_mosi_q = '{8'h61, 8'hFF, 8'h61, 8'hFF};
        exp_rdata_q = '{8'h11, 8'h22};
        cmd = 8'h61;
        len = 6'd1;
        rw  = 1'b0;
        req = 1'b1;
        for (int i = 0; i < 3000 && n_done < 1; i++) tick();
        checkOutput("b2b_starts_at_done1", n_start, 2);
        for (int i = 0; i < 3000 && n_start < 3; i++) tick();
        req = 1'b0;
        for (int i = 0; i < 3000 && n_done < 2; i++) tick();
        repeat (20) tick();
        checkOutput("b2b_done_count", n_done, 2);
        checkOutput("b2b_starts", n_start, 4);
        checkOutput("b2b_rdata_valid", n_rvalid, 2);
        checkOutput("b2b_csn_falls", csn_falls, 2);
        checkOutput("b2b_start_while_busy", start_while_busy, 0);
        checkOutput("b2b_rdata_left", exp_rdata_q.size(), 0);
        if (start_cyc_q.size() >= 3 && rise_cyc_q.size() >= 1)
            checkOutput("b2b_gap_ok", int'((start_cyc_q[2] - rise_cyc_q[0]) >= GAP_CYCLES), 1);
        else
            checkOutput("b2b_gap_events", start_cyc_q.size(), 4);

        // Reset in the middle of read data byte 2.
        loadTxn(vecs[1]);
        issueReq(vecs[1]);
        for (int i = 0; i < 2000 && n_start < 3; i++) tick();
        checkOutput("rst_mid_reached_byte2", n_start, 3);
        repeat (5) tick();
        rst = 1'b0;
        tick();
        checkOutput("rst_mid_busy", int'(busy), 0);
        checkOutput("rst_mid_hold_csn", int'(spi_hold_csn), 0);
        checkOutput("rst_mid_master_busy", int'(spi_busy), 0);
        tick();
        rst = 1'b1;
        repeat (40) tick();
        checkOutput("rst_mid_no_done", n_done, 0);
        checkOutput("rst_mid_rdata_valid", n_rvalid, 1);
        checkOutput("rst_mid_starts", n_start, 3);

        applyStimulus(vecs[1]);
        checkTxn(vecs[1], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nrf_spi_txn_ctrl.md
Name: nrf_spi_txn_ctrl

Overview:
- Transaction sequencer directly upstream of the byte-level SPI master (Mode 0) driving the nRF24L01 radio.
- Turns one request into one complete CSN-framed SPI transaction: a command byte followed by 0..MAX_LEN data bytes.
- Holds CSN low across all bytes via hold_csn; captures the radio STATUS byte; streams write payload in and read payload out.

Parameters:
- MAX_LEN, 32, maximum data bytes per transaction; larger len is clamped to this.
- GAP_CYCLES, 8, clk cycles CSN must stay high after a transaction before the next may start (minimum 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  start-transaction pulse; sampled only in IDLE.
- cmd  in  8  command byte; latched on accepted req.
- len  in  6  data byte count; latched on accepted req.
- rw  in  1  1 = write payload from wdata stream; 0 = read, send 8'hFF per data byte.
- wdata  in  8  write payload byte.
- wdata_valid  in  1  wdata is available.
- wdata_ready  out  1  wdata consumed this cycle.
- rdata  out  8  received read byte.
- rdata_valid  out  1  1-cycle pulse per received read byte.
- status  out  8  rx byte of the command phase (nRF STATUS).
- busy  out  1  transaction in progress, including the gap.
- done  out  1  1-cycle pulse at end of gap.
- spi_start  out  1  1-cycle byte-start pulse to the SPI master.
- spi_tx_byte  out  8  byte to send; held stable from spi_start until spi_done.
- spi_rx_byte  in  8  byte received by the SPI master.
- spi_done  in  1  SPI master byte-complete pulse.
- spi_busy  in  1  SPI master busy.
- spi_hold_csn  out  1  keeps CSN asserted between bytes.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0 except spi_tx_byte=8'h00 and status=8'h00. spi_hold_csn=0, so the master releases CSN.
- All outputs are registered.
- IDLE:
  - busy=0.
  - If req=1: latch cmd, rw, and len_eff = min(len, MAX_LEN); set busy=1; go CMD_ISSUE.
  - req in any other state is ignored (no queueing).
- CMD_ISSUE:
  - Wait spi_busy=0.
  - Then in one cycle: spi_start=1, spi_tx_byte=cmd, spi_hold_csn=1. Go CMD_WAIT.
- CMD_WAIT:
  - On spi_done: status <= spi_rx_byte.
  - If len_eff=0, go LAST; else go DATA_FETCH.
- DATA_FETCH:
  - rw=0: load 8'hFF and go DATA_ISSUE.
  - rw=1: wait wdata_valid. Pulse wdata_ready=1 for exactly one cycle while loading spi_tx_byte=wdata, then go DATA_ISSUE.
  - Stalls indefinitely on missing wdata. CSN stays low and SCLK idles low.
- DATA_ISSUE: wait spi_busy=0, pulse spi_start, go DATA_WAIT.
- DATA_WAIT:
  - On spi_done: if rw=0, rdata <= spi_rx_byte and rdata_valid pulses the cycle after spi_done.
  - Decrement remaining count. If 0, go LAST; else go DATA_FETCH.
- LAST:
  - spi_hold_csn <= 0 (cycle after the final spi_done).
  - Wait spi_busy=0, then go GAP with counter reset.
- GAP:
  - Count GAP_CYCLES clk.
  - Then done=1 for one cycle, busy=0, go IDLE.
  - A req coinciding with the done cycle is ignored; it is accepted only in IDLE.
- spi_start is never asserted while spi_busy=1.
- Exactly 1+len_eff spi_start pulses are issued per transaction.
- spi_done outside CMD_WAIT/DATA_WAIT is ignored.
- Remaining-byte counter is 6 bits; no wrap because len_eff ≤ 32.
- Reset mid-transaction:
  - Immediate return to IDLE; spi_hold_csn=0.
  - The SPI master is reset on the same net and aborts its byte.
  - No done pulse, no rdata_valid.

Test Plan:
- Write: req, cmd=8'h20, len=1, rw=1, wdata=8'h0E valid; slave MISO status 8'h0E → MOSI bytes 20,0E under a single CSN low; status=8'h0E; one wdata_ready; done ≥GAP_CYCLES after CSN high; no rdata_valid.
- Read: req, cmd=8'h61, len=3, rw=0; slave returns 0E,A1,B2,C3 → MOSI 61,FF,FF,FF; rdata_valid ×3 with A1,B2,C3 in order; status=8'h0E; CSN low continuously for 4 bytes.
- Command-only: cmd=8'hE1, len=0 → exactly one spi_start; spi_hold_csn drops after first spi_done; done pulses; wdata_ready never asserted.
- Clamp and stall: len=40, rw=1, wdata_valid low for 50 cycles before byte 3 → 33 spi_start total; CSN held low during stall with no SCLK activity; 32 wdata_ready pulses.
- Back-to-back: req held high continuously → second transaction's first spi_start no earlier than GAP_CYCLES after first CSN rise; req during busy produces no extra bytes.
- Reset mid-read (rst low during data byte 2) → busy=0, spi_hold_csn=0, CSN high, no done; a fresh req afterwards completes normally.
